// File: rtl/axis_uart_rx_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding, error flags
// and the parity helper used by both directions of the link.
package axis_uart_rx_pkg;

  localparam int DATA_WIDTH       = 8;
  localparam int DIVIDER_WIDTH    = 32;
  localparam int UART_MIN_DIVIDER = 4;
  localparam int UART_SYNC_STAGES = 2;

  typedef logic [DIVIDER_WIDTH-1:0] uart_clk_divider_reg_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT
  } uart_state_e;

  typedef struct packed {
    logic frame;
    logic parity;
  } uart_rx_err_t;

  // Expected parity bit for a data byte; odd wins when both enables are set.
  function automatic logic parity(input logic [DATA_WIDTH-1:0] data,
                                  input logic odd,
                                  input logic even);
    logic bit_val;
    bit_val = 1'b0;
    if (odd) begin
      bit_val = ~^data;
    end else if (even) begin
      bit_val = ^data;
    end
    return bit_val;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous single-bit input with a selectable
// reset value, so an idle-high line does not look like activity after reset.
module uart_sync
  import axis_uart_rx_pkg::*;
#(
  parameter int   STAGES    = UART_SYNC_STAGES,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver: samples the synchronized line at mid-bit, rebuilds each frame
// and hands the byte plus its error flags to an AXI-Stream consumer.
module axis_uart_rx
  import axis_uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     uart_rx_i,
  input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
  input  logic                     parity_odd_i,
  input  logic                     parity_even_i,
  input  logic                     rx_reset_i,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
  output logic [1:0]               m_axis_tuser_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic                     overrun_o,
  output logic                     busy_o,
  output uart_state_e              state_o
);

  localparam int BIT_IDX_W = $clog2(DATA_WIDTH);
  localparam logic [DIVIDER_WIDTH-1:0] MIN_DIV = DIVIDER_WIDTH'(UART_MIN_DIVIDER);
  localparam logic [DIVIDER_WIDTH-1:0] ONE     = DIVIDER_WIDTH'(1);
  localparam logic [BIT_IDX_W-1:0]     LAST_BIT = BIT_IDX_W'(DATA_WIDTH - 1);

  logic rx_s;

  uart_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (uart_rx_i),
    .q_o   (rx_s)
  );

  uart_state_e              state_q, state_d;
  logic [DIVIDER_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIVIDER_WIDTH-1:0] div_q, div_sel;
  logic [BIT_IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]    shift_q, shift_d;
  logic                     par_odd_q, par_even_q, par_en;
  logic                     par_err_q, par_err_d;
  logic                     latch_cfg, deliver, frm_err;
  logic                     tick, mid_start;
  uart_rx_err_t             err;

  assign div_sel   = (clk_divider_i < MIN_DIV) ? MIN_DIV : clk_divider_i;
  assign par_en    = par_odd_q | par_even_q;
  assign tick      = (cnt_q == div_q - ONE);
  assign mid_start = (cnt_q == (div_q >> 1) - ONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + ONE;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    latch_cfg = 1'b0;
    deliver   = 1'b0;
    frm_err   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d   = START;
          latch_cfg = 1'b1;
          par_err_d = 1'b0;
        end
      end
      START: begin
        if (mid_start) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = par_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_d     = '0;
          par_err_d = (rx_s != parity(shift_q, par_odd_q, par_even_q));
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d   = '0;
          frm_err = ~rx_s;
          deliver = 1'b1;
          state_d = rx_s ? IDLE : WAIT;
        end
      end
      WAIT: begin
        // A held-low line (break) must return high before a new start counts.
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      div_q      <= MIN_DIV;
      par_odd_q  <= 1'b0;
      par_even_q <= 1'b0;
    end else if (rx_reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      div_q      <= MIN_DIV;
      par_odd_q  <= 1'b0;
      par_even_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      if (latch_cfg) begin
        div_q      <= div_sel;
        par_odd_q  <= parity_odd_i;
        par_even_q <= parity_even_i;
      end
    end
  end

  assign err = '{frame: frm_err, parity: par_err_q};

  // Stream handshake: a beat transfers on a clock edge where tvalid and tready
  // are both high; tvalid only falls after such an edge, and tdata/tuser hold
  // while tvalid && !tready. A new byte loads only into an empty or draining
  // slot, otherwise it is dropped and overrun_o pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_axis_tdata_o  <= '0;
      m_axis_tuser_o  <= '0;
      m_axis_tvalid_o <= 1'b0;
      overrun_o       <= 1'b0;
    end else if (rx_reset_i) begin
      m_axis_tdata_o  <= '0;
      m_axis_tuser_o  <= '0;
      m_axis_tvalid_o <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (deliver) begin
        if (!m_axis_tvalid_o || m_axis_tready_i) begin
          m_axis_tdata_o  <= shift_q;
          m_axis_tuser_o  <= err;
          m_axis_tvalid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (m_axis_tvalid_o && m_axis_tready_i) begin
        m_axis_tvalid_o <= 1'b0;
      end
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;

endmodule

// File: doc/axis_uart_rx.md
Name: axis_uart_rx

Overview:
- UART receive stage. Sits between the asynchronous serial RX pin and the AXI-Stream consumer, downstream of the pin and upstream of the register/command layer.
- Recovers 8-bit frames (start, 8 data LSB-first, optional parity, 1 stop) using the shared clock divider and control register fields.
- Presents each received byte on an AXI-Stream master with per-byte error flags.

Parameters:
- DATA_WIDTH, 8, data bits per frame (package constant; only 8 is supported).
- DIVIDER_WIDTH, 32, width of the clock divider (package constant).
- SYNC_STAGES, 2, number of input synchronizer flops (must be ≥2).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- uart_rx_i  in  1  serial line, asynchronous, idle high
- clk_divider_i  in  DIVIDER_WIDTH  clk_i cycles per bit (uart_clk_divider_reg_t)
- parity_odd_i  in  1  control.parity_odd
- parity_even_i  in  1  control.parity_even
- rx_reset_i  in  1  control.rx_reset, synchronous soft reset
- m_axis_tdata_o  out  DATA_WIDTH  received byte
- m_axis_tuser_o  out  2  [0] parity error, [1] frame error
- m_axis_tvalid_o  out  1  byte valid
- m_axis_tready_i  in  1  consumer ready
- overrun_o  out  1  one-cycle pulse when a completed byte is dropped
- busy_o  out  1  high whenever the state is not IDLE

Behaviour:
- Reset and outputs:
  - rst_i asserted (async) or rx_reset_i high at a clock edge: state=IDLE, counters=0, tdata=0, tuser=0, tvalid=0, overrun=0, busy=0.
  - The synchronizer chain resets to all-ones (idle line).
- Input path: uart_rx_i passes through SYNC_STAGES flops. All decisions use the synchronized value rx_s.
- Divider:
  - div = max(clk_divider_i, 4).
  - Latched into div_q on IDLE→START.
  - Changes mid-frame have no effect on the current frame.
- Parity:
  - Enabled when parity_odd_i | parity_even_i. Odd takes precedence when both are set.
  - Expected bit = package parity(data, odd, even): odd → ~^data, even → ^data.
  - Parity enables are latched with div_q.
- Bit counter: cnt counts 0..div_q-1. The "tick" is cnt == div_q-1, after which cnt wraps to 0.
- State machine (uart_state_e):
  - IDLE: rx_s==0 → START, cnt=0.
  - START: at cnt == div_q/2 - 1 (mid start bit):
    - rx_s==1 → IDLE (glitch, no output).
    - otherwise cnt=0 → DATA, bit_idx=0.
  - DATA: on each tick, shift rx_s into data MSB (LSB-first reception) and increment bit_idx. After bit 7 → PARITY if parity is enabled, else STOP.
  - PARITY: on tick, par_err = (rx_s != expected) → STOP.
  - STOP: on tick, frm_err = (rx_s==0), then deliver (see below).
    - frm_err=0 → IDLE.
    - frm_err=1 → WAIT.
  - WAIT (break / framing recovery): stay until rx_s==1, then → IDLE. No new start is detected while in WAIT.
- Delivery (STOP tick):
  - If tvalid==0, or tvalid && tready in the same cycle: load tdata, tuser={frm_err, par_err}, tvalid=1.
  - Otherwise drop the new byte, pulse overrun_o for 1 cycle, and leave the held output unchanged.
  - A byte with errors is still delivered.
- AXIS rules:
  - tvalid is deasserted only after a cycle with tvalid && tready.
  - tdata/tuser are stable while tvalid && !tready.
- Latency: tvalid rises 1 clk after the STOP mid-bit tick, about (9.5 + parity) × div cycles after the start edge, plus SYNC_STAGES.
- Mid-frame events:
  - rx_reset_i mid-frame aborts the frame.
  - A pending tvalid is also cleared (the byte is lost).

Decomposition:
- Package additions:
  - uart_rx_err_t packed struct {frame, parity}.
  - UART_MIN_DIVIDER = 4.
  - UART_SYNC_STAGES = 2.
- Reuse from the package: DATA_WIDTH, DIVIDER_WIDTH, uart_state_e, parity().
- Natural sub-module: uart_sync (N-flop synchronizer, parameterised reset value). It is reusable by the TX stage for the CTS input.

Test Plan:
1. div=16, no parity, send 0xA5, tready=1 → one beat: tdata=0xA5, tuser=00. tvalid rises at 152±2+SYNC_STAGES cycles after the start edge.
2. div=16, parity_odd=1, send 0x03 with parity bit 1 → tuser=00. Same byte with parity bit 0 → tdata=0x03, tuser=01.
3. div=16, line low for 5 cycles then high → no tvalid, state returns to IDLE. A following 0x5A is received correctly.
4. div=16, tready=0, send 0x11 then 0x22 → tdata holds 0x11, overrun_o pulses once at the 0x22 stop tick. Raise tready → single beat 0x11, then tvalid=0.
5. div=16, send 0x00 with stop bit 0, line held low 40 bit-times → tdata=0x00, tuser=10, busy stays high (WAIT). Line high → IDLE. Next byte 0x7E OK.
6. Assert rx_reset_i during DATA bit 4, and separately assert rst_i asynchronously between clocks → tvalid=0 and busy=0 immediately (rst_i) or next edge (rx_reset_i). A subsequent 0xC3 is received cleanly. clk_divider_i=2 behaves as div=4.
